// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int unsigned slice_width(int unsigned width, int unsigned stages);
        return width / stages;
    endfunction

    function automatic bit params_ok(int unsigned width, int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// Combinational SW-bit ripple chain of full adders; also exposes the carry into its MSB.
module rca_slice #(
    parameter int unsigned SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);

    logic [SW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SW; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    assign cout     = c[SW];
    assign c_msb_in = c[SW-1];

endmodule

// File: rtl/rca_pipelined.sv
// Pipelined ripple-carry adder/subtractor: one SW-bit slice per stage, skewed operands,
// deskewed sum, global stall driven by the output handshake.
module rca_pipelined
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned SW = slice_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("rca_pipelined: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic             advance;
    logic [WIDTH-1:0] y_eff;
    logic             cin0;
    logic             ov_q;

    assign y_eff = (sub == MODE_SUB) ? ~y : y;
    assign cin0  = (sub == MODE_SUB) ? 1'b1 : carry_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed when slice k is evaluated.
        localparam int unsigned RW = (STAGES - k) * SW;

        logic [RW-1:0]         xin;
        logic [RW-1:0]         yin;
        logic                  cin;
        logic [SW-1:0]         s;
        logic                  cout;
        logic                  c_msb;
        logic                  v_q;
        logic                  c_q;
        logic [(k+1)*SW-1:0]   s_q;

        rca_slice #(.SW(SW)) u_slice (
            .a       (xin[SW-1:0]),
            .b       (yin[SW-1:0]),
            .cin     (cin),
            .s       (s),
            .cout    (cout),
            .c_msb_in(c_msb)
        );

        if (k == 0) begin : g_first
            assign xin = x;
            assign yin = y_eff;
            assign cin = cin0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (advance) begin
                    v_q <= in_valid;
                    c_q <= cout;
                    s_q <= s;
                end
            end
        end else begin : g_rest
            assign cin = g_stage[k-1].c_q;

            // Operand skew registers sit alongside the previous stage's carry/sum registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xin <= '0;
                    yin <= '0;
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (advance) begin
                    xin <= g_stage[k-1].xin[RW+SW-1:SW];
                    yin <= g_stage[k-1].yin[RW+SW-1:SW];
                    v_q <= g_stage[k-1].v_q;
                    c_q <= cout;
                    s_q <= {s, g_stage[k-1].s_q};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
        end else if (advance) begin
            ov_q <= g_stage[STAGES-1].c_msb ^ g_stage[STAGES-1].cout;
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign carry_out = g_stage[STAGES-1].c_q;
    assign overflow  = ov_q;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

endmodule
